// File: rtl/bm_pkg.sv
// Shared types and constants for the Box-Muller sample scheduler.
package bm_pkg;

  localparam int SAMPLE_W    = 16;
  localparam int SEED_W      = 32;
  localparam int LOAD_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_WARM,
    ST_RUN
  } state_e;

endpackage

// File: rtl/bm_sched_if.sv
// Link between the scheduler and its pair-write / single-read sample FIFO.
interface bm_sched_if #(
  parameter int DEPTH = 8
);
  import bm_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic                flush;
  logic                push;
  logic                pop;
  logic [SAMPLE_W-1:0] din0;
  logic [SAMPLE_W-1:0] din1;
  logic [SAMPLE_W-1:0] head;
  logic [CW-1:0]       count;

  modport master (output flush, push, pop, din0, din1, input head, count);
  modport slave  (input flush, push, pop, din0, din1, output head, count);

endinterface

// File: rtl/bm_pair_fifo.sv
// Sample FIFO: writes a whole pair (din0 then din1) per push, pops one sample per read.
module bm_pair_fifo
  import bm_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  bm_sched_if.slave  fifo
);

  localparam int AW = $clog2(DEPTH);

  logic [SAMPLE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q;
  logic [AW-1:0]       rd_ptr_q;
  logic [AW:0]         count_q;

  // NOTE: storage carries no reset; occupancy alone defines what is valid, so resetting it only costs flops.
  always_ff @(posedge clk) begin
    if (fifo.push && !fifo.flush) begin
      mem_q[wr_ptr_q]          <= fifo.din0;
      mem_q[wr_ptr_q + AW'(1)] <= fifo.din1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (fifo.flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (fifo.push) wr_ptr_q <= wr_ptr_q + AW'(2);
      if (fifo.pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (fifo.push ? (AW+1)'(2) : '0) - (fifo.pop ? (AW+1)'(1) : '0);
    end
  end

  assign fifo.head  = mem_q[rd_ptr_q];
  assign fifo.count = count_q;

endmodule

// File: rtl/bm_sched.sv
// Seeds and warms up a Box-Muller core, buffers its sample pairs and hands them out round-robin.
// Optional overflow statistics: define BM_SCHED_STATS_EN to build the ovf_cnt counter.
module bm_sched
  import bm_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int WARMUP = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SEED_W-1:0]   seed1_cfg,
  input  logic [SEED_W-1:0]   seed2_cfg,
  input  logic                reseed,
  output logic                bm_reset,
  output logic [SEED_W-1:0]   bm_seed1,
  output logic [SEED_W-1:0]   bm_seed2,
  input  logic                bm_v,
  input  logic [SAMPLE_W-1:0] bm_x0,
  input  logic [SAMPLE_W-1:0] bm_x1,
  input  logic [1:0]          req,
  output logic [1:0]          gnt,
  output logic [SAMPLE_W-1:0] dout,
  output logic                dout_valid,
  output logic                ready,
  output logic [7:0]          ovf_cnt
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int LCW = (LOAD_CYCLES < 2) ? 1 : $clog2(LOAD_CYCLES);
  localparam int WCW = (WARMUP < 2) ? 1 : $clog2(WARMUP);

  state_e              state_q, state_d;
  logic [LCW-1:0]      load_cnt_q, load_cnt_d;
  logic [WCW-1:0]      warm_cnt_q, warm_cnt_d;
  logic [SEED_W-1:0]   seed1_q, seed2_q;
  logic                prio_q, prio_d;
  logic [1:0]          gnt_q, grant_d;
  logic [SAMPLE_W-1:0] dout_q;
  logic                dout_valid_q;

  logic                run;
  logic                room;
  logic                push;
  logic [CW-1:0]       fifo_free;

  bm_sched_if #(.DEPTH(DEPTH)) fifo_if ();

  bm_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .fifo  (fifo_if.slave)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    warm_cnt_d = warm_cnt_q;
    if (reseed) begin
      state_d    = ST_LOAD;
      load_cnt_d = '0;
      warm_cnt_d = '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          warm_cnt_d = '0;
          if (load_cnt_q == LCW'(LOAD_CYCLES - 1)) begin
            state_d    = ST_WARM;
            load_cnt_d = '0;
          end else begin
            load_cnt_d = load_cnt_q + LCW'(1);
          end
        end
        ST_WARM: begin
          if (WARMUP == 0) begin
            state_d = ST_RUN;
          end else if (bm_v) begin
            if (warm_cnt_q == WCW'(WARMUP - 1)) state_d = ST_RUN;
            else                                warm_cnt_d = warm_cnt_q + WCW'(1);
          end
        end
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_LOAD;
      endcase
    end
  end

  // Free space is judged on pre-pop occupancy; a same-cycle pop never makes room for a pair.
  assign run       = (state_q == ST_RUN);
  assign fifo_free = CW'(DEPTH) - fifo_if.count;
  assign room      = (fifo_free >= CW'(2));
  assign push      = run && bm_v && room && !reseed;

  always_comb begin
    grant_d = '0;
    prio_d  = prio_q;
    if (run && !reseed && (fifo_if.count != '0)) begin
      if (req[prio_q])       grant_d[prio_q]  = 1'b1;
      else if (req[!prio_q]) grant_d[!prio_q] = 1'b1;
    end
    if (grant_d[0])      prio_d = 1'b1;
    else if (grant_d[1]) prio_d = 1'b0;
  end

  assign fifo_if.flush = reseed || (state_q == ST_LOAD);
  assign fifo_if.push  = push;
  assign fifo_if.pop   = |grant_d;
  assign fifo_if.din0  = bm_x0;
  assign fifo_if.din1  = bm_x1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_LOAD;
      load_cnt_q   <= '0;
      warm_cnt_q   <= '0;
      seed1_q      <= '0;
      seed2_q      <= '0;
      prio_q       <= 1'b0;
      gnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      warm_cnt_q   <= warm_cnt_d;
      prio_q       <= prio_d;
      gnt_q        <= grant_d;
      dout_valid_q <= |grant_d;
      if (|grant_d) dout_q <= fifo_if.head;
      if (state_q == ST_LOAD && load_cnt_q == '0) begin
        seed1_q <= seed1_cfg;
        seed2_q <= seed2_cfg;
      end
    end
  end

`ifdef BM_SCHED_STATS_EN
  logic       drop;
  logic [7:0] ovf_q;

  assign drop = run && bm_v && !room && !reseed;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       ovf_q <= '0;
    else if (drop && ovf_q != 8'hFF)  ovf_q <= ovf_q + 8'd1;
  end

  assign ovf_cnt = ovf_q;
`else
  assign ovf_cnt = '0;
`endif

  assign bm_reset   = (state_q == ST_LOAD);
  assign bm_seed1   = seed1_q;
  assign bm_seed2   = seed2_q;
  assign gnt        = gnt_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign ready      = run;

endmodule

// File: tb/tb_bm_sched.sv
// Directed self-checking bench for bm_sched (DEPTH=8, WARMUP=4); follows BM_SCHED_STATS_EN for ovf_cnt.
module tb_bm_sched;
  import bm_pkg::*;

`ifdef BM_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic [SEED_W-1:0]   seed1_cfg, seed2_cfg;
  logic                reseed;
  logic                bm_reset;
  logic [SEED_W-1:0]   bm_seed1, bm_seed2;
  logic                bm_v;
  logic [SAMPLE_W-1:0] bm_x0, bm_x1;
  logic [1:0]          req;
  logic [1:0]          gnt;
  logic [SAMPLE_W-1:0] dout;
  logic                dout_valid;
  logic                ready;
  logic [7:0]          ovf_cnt;

  int checks = 0;
  int errors = 0;

  bm_sched #(.DEPTH(8), .WARMUP(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .seed1_cfg  (seed1_cfg),
    .seed2_cfg  (seed2_cfg),
    .reseed     (reseed),
    .bm_reset   (bm_reset),
    .bm_seed1   (bm_seed1),
    .bm_seed2   (bm_seed2),
    .bm_v       (bm_v),
    .bm_x0      (bm_x0),
    .bm_x1      (bm_x1),
    .req        (req),
    .gnt        (gnt),
    .dout       (dout),
    .dout_valid (dout_valid),
    .ready      (ready),
    .ovf_cnt    (ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [1:0]          exp_g [10];
    logic [SAMPLE_W-1:0] exp_d [8];
    logic [SAMPLE_W-1:0] exp_c [6];
    int                  k;

    exp_g = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
    exp_d = '{16'hA000, 16'hB000, 16'hA001, 16'hB001, 16'hA002, 16'hB002, 16'hA003, 16'hB003};
    exp_c = '{16'hC010, 16'hC011, 16'hC020, 16'hC021, 16'hC030, 16'hC031};

    reset     = 1'b0;
    seed1_cfg = 32'h0006_7580;
    seed2_cfg = 32'h0007_0385;
    reseed    = 1'b0;
    bm_v      = 1'b0;
    bm_x0     = '0;
    bm_x1     = '0;
    req       = 2'b00;

    // Reset values
    repeat (3) tick();
    check("rst_bm_reset", bm_reset, 1);
    check("rst_seed1", bm_seed1, 0);
    check("rst_seed2", bm_seed2, 0);
    check("rst_gnt", gnt, 0);
    check("rst_dout", dout, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_ready", ready, 0);
    check("rst_ovf", ovf_cnt, 0);

    // LOAD: two cycles of bm_reset, seeds latched
    reset = 1'b1;
    tick();
    check("load1_bm_reset", bm_reset, 1);
    check("load_seed1", bm_seed1, 32'h0006_7580);
    check("load_seed2", bm_seed2, 32'h0007_0385);
    tick();
    check("load_done_bm_reset", bm_reset, 0);
    check("warm_ready", ready, 0);

    // WARM: four discarded pairs
    for (int i = 0; i < 4; i++) begin
      bm_v  = 1'b1;
      bm_x0 = 16'hDEA0 + 16'(i);
      bm_x1 = 16'hBEE0 + 16'(i);
      tick();
      if (i == 2) check("warm3_ready", ready, 0);
    end
    bm_v = 1'b0;
    check("warm4_ready", ready, 1);
    req = 2'b11;
    tick();
    check("warm_pairs_dropped_valid", dout_valid, 0);
    check("warm_pairs_dropped_gnt", gnt, 0);

    // RUN: round-robin alternation with continuous pairs
    k = 0;
    for (int i = 0; i < 10; i++) begin
      bm_v  = (i < 4);
      bm_x0 = 16'hA000 + 16'(i);
      bm_x1 = 16'hB000 + 16'(i);
      tick();
      check($sformatf("rr_gnt[%0d]", i), gnt, exp_g[i]);
      check($sformatf("rr_valid[%0d]", i), dout_valid, (exp_g[i] != 2'b00));
      if (exp_g[i] != 2'b00) begin
        check($sformatf("rr_dout[%0d]", i), dout, exp_d[k]);
        k++;
      end
    end
    bm_v = 1'b0;
    check("dout_hold", dout, 16'hB003);

    // Overflow: five pairs into an 8-deep FIFO, no requests
    req = 2'b00;
    for (int i = 0; i < 5; i++) begin
      bm_v  = 1'b1;
      bm_x0 = 16'hC000 + 16'(i * 16);
      bm_x1 = 16'hC001 + 16'(i * 16);
      tick();
    end
    bm_v = 1'b0;
    check("ovf_after_5", ovf_cnt, STATS ? 1 : 0);
    check("full_no_grant_valid", dout_valid, 0);
    check("full_dout_hold", dout, 16'hB003);

    // Pop to 7, then pair + grant in the same cycle: pair dropped
    req = 2'b01;
    tick();
    check("pop7_gnt", gnt, 2'b01);
    check("pop7_dout", dout, 16'hC000);
    bm_v  = 1'b1;
    bm_x0 = 16'hE000;
    bm_x1 = 16'hE001;
    tick();
    bm_v = 1'b0;
    check("prepop7_dout", dout, 16'hC001);
    check("prepop7_ovf", ovf_cnt, STATS ? 2 : 0);
    for (int j = 0; j < 6; j++) begin
      tick();
      check($sformatf("drain_gnt[%0d]", j), gnt, 2'b01);
      check($sformatf("drain_dout[%0d]", j), dout, exp_c[j]);
    end
    tick();
    check("drained_valid", dout_valid, 0);
    check("drained_gnt", gnt, 0);

    // Saturation of ovf_cnt
    req = 2'b00;
    for (int i = 0; i < 4; i++) begin
      bm_v  = 1'b1;
      bm_x0 = 16'h5000 + 16'(i);
      bm_x1 = 16'h5100 + 16'(i);
      tick();
    end
    repeat (260) tick();
    bm_v = 1'b0;
    check("ovf_saturate", ovf_cnt, STATS ? 255 : 0);

    // Reseed in RUN with a grant in flight and a full FIFO
    req = 2'b11;
    tick();
    check("pre_reseed_gnt", gnt, 2'b10);
    check("pre_reseed_valid", dout_valid, 1);
    check("pre_reseed_dout", dout, 16'h5000);
    seed1_cfg = 32'h1234_5678;
    seed2_cfg = 32'h9ABC_DEF0;
    reseed    = 1'b1;
    tick();
    reseed = 1'b0;
    check("reseed_bm_reset", bm_reset, 1);
    check("reseed_gnt", gnt, 0);
    check("reseed_valid", dout_valid, 0);
    check("reseed_ready", ready, 0);
    check("reseed_ovf_kept", ovf_cnt, STATS ? 255 : 0);
    tick();
    check("reseed_seed1", bm_seed1, 32'h1234_5678);
    check("reseed_seed2", bm_seed2, 32'h9ABC_DEF0);
    check("reseed_load2_bm_reset", bm_reset, 1);
    tick();
    check("reseed_warm_bm_reset", bm_reset, 0);

    // Reseed mid-WARM: warm-up count restarts
    bm_v = 1'b1;
    repeat (2) tick();
    bm_v = 1'b0;
    check("midwarm_ready", ready, 0);
    reseed = 1'b1;
    tick();
    reseed = 1'b0;
    check("midwarm_reseed_bm_reset", bm_reset, 1);
    repeat (2) tick();
    check("midwarm_load_done", bm_reset, 0);
    for (int i = 0; i < 4; i++) begin
      bm_v = 1'b1;
      tick();
      if (i == 2) check("warm_restart_ready", ready, 0);
    end
    bm_v = 1'b0;
    check("warm_restart_done", ready, 1);
    tick();
    check("flushed_valid", dout_valid, 0);
    check("flushed_ovf_kept", ovf_cnt, STATS ? 255 : 0);

    // Asynchronous reset during RUN with dout_valid high
    bm_v  = 1'b1;
    bm_x0 = 16'h7000;
    bm_x1 = 16'h7001;
    tick();
    bm_v = 1'b0;
    tick();
    check("pre_arst_gnt", gnt, 2'b01);
    check("pre_arst_valid", dout_valid, 1);
    check("pre_arst_dout", dout, 16'h7000);
    reset = 1'b0;
    #1;
    check("arst_bm_reset", bm_reset, 1);
    check("arst_seed1", bm_seed1, 0);
    check("arst_seed2", bm_seed2, 0);
    check("arst_gnt", gnt, 0);
    check("arst_dout", dout, 0);
    check("arst_valid", dout_valid, 0);
    check("arst_ready", ready, 0);
    check("arst_ovf", ovf_cnt, 0);

    // After reset, requester 0 wins the first tie
    tick();
    reset = 1'b1;
    repeat (2) tick();
    bm_v = 1'b1;
    repeat (4) tick();
    check("rerun_ready", ready, 1);
    bm_x0 = 16'h8000;
    bm_x1 = 16'h8001;
    tick();
    bm_v = 1'b0;
    tick();
    check("tie_after_reset_gnt", gnt, 2'b01);
    check("tie_after_reset_dout", dout, 16'h8000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bm_sched.md
BM_SCHED -- requirements
Module: bm_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 8: sample FIFO depth in 16-bit entries (power of 2, at least 4).
REQ-002 SHALL have parameter WARMUP, default 4: number of BM output pairs discarded after each (re)seed.
REQ-003 SHALL have ports, one per line:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- seed1_cfg, seed2_cfg  in  32 each  seed values loaded on reseed.
- reseed  in  1  single-cycle pulse requesting a reseed.
- bm_reset  out  1  active-high reset to the BM core.
- bm_seed1, bm_seed2  out  32 each  seeds to the BM core.
- bm_v  in  1  BM pair valid.
- bm_x0, bm_x1  in  16 each  BM Gaussian samples.
- req  in  2  per-requester sample request, level.
- gnt  out  2  one-hot grant, registered.
- dout  out  16  sample delivered to the granted requester.
- dout_valid  out  1  dout qualifier.
- ready  out  1  high in RUN.
- ovf_cnt  out  8  saturating count of dropped pairs.

Function
REQ-004 SHALL implement the FSM states LOAD, WARM and RUN; reset enters LOAD.
REQ-005 LOAD SHALL hold bm_reset=1 for exactly 2 cycles, latch seed1_cfg/seed2_cfg onto bm_seed1/bm_seed2 on entry, flush the FIFO, and then go to WARM.
REQ-006 WARM SHALL discard the first WARMUP bm_v pairs, then go to RUN; ready=1 only in RUN.
REQ-007 A reseed pulse in any state SHALL go to LOAD on the next cycle, aborting the warm-up, flushing the FIFO and dropping any in-flight grant.
REQ-008 In RUN, each bm_v SHALL write x0 then x1 (x0 first in read order) in one cycle when at least 2 entries are free.
REQ-009 If fewer than 2 entries are free, the whole pair SHALL be dropped and ovf_cnt incremented, saturating at 255.
REQ-010 Arbitration SHALL be round-robin over req: at most one grant per cycle, only when the FIFO is non-empty; the last-granted requester has the lower priority next cycle; requester 0 wins the first tie after reset.
REQ-011 The grant decision is made in cycle N; gnt, dout (FIFO head) and dout_valid SHALL be registered and visible in cycle N+1, and the FIFO SHALL pop once per grant.
REQ-012 On the same cycle, a simultaneous push of 2 and pop of 1 SHALL be legal; free-space evaluation SHALL use the occupancy before the pop.
REQ-013 When no grant is made, gnt=0 and dout_valid=0, and dout SHALL hold its last value.
REQ-014 FIFO pointers SHALL wrap modulo DEPTH, and occupancy SHALL be tracked as log2(DEPTH)+1 bits.

Reset
REQ-015 With reset=0: state=LOAD, bm_reset=1, bm_seed1=bm_seed2=0, FIFO empty, gnt=0, dout=0, dout_valid=0, ready=0, ovf_cnt=0, round-robin pointer=0.
REQ-016 Deasserting reset SHALL start LOAD timing on the first following clk edge.
REQ-017 The LOAD sequence SHALL latch the seeds from seed1_cfg/seed2_cfg.
REQ-018 ovf_cnt SHALL clear only on reset, not on reseed.

Configuration
REQ-019 With macro BM_SCHED_STATS_EN defined, the ovf_cnt logic SHALL be present and SHALL behave as in REQ-009.
REQ-020 Without BM_SCHED_STATS_EN, ovf_cnt SHALL be constant 0 and no counter flops SHALL be inferred; dropping behaviour is unchanged.

Structure
REQ-021 A shared package bm_pkg SHALL hold the FSM state typedef (LOAD/WARM/RUN), the sample width constant (16), the seed width constant (32) and the LOAD hold length (2).
REQ-022 The FIFO SHALL be the sub-module bm_pair_fifo, with a dual-write (pair) input and a single-read output.
REQ-023 The FSM, arbiter and output registers SHALL live in bm_sched.

Verification
REQ-024 Reset released, seeds 0x67580/0x70385 -> bm_reset high for 2 cycles, bm_seed1=0x67580 and bm_seed2=0x70385, the first 4 bm_v pairs are not stored, and ready rises after the 4th pair.
REQ-025 RUN, req=2'b11 held, continuous bm_v -> gnt alternates 01,10,01,...; dout order equals x0(k), x1(k), x0(k+1), ...
REQ-026 RUN, req=0, DEPTH=8, 5 bm_v pairs -> FIFO holds 8 samples; pair 5 is dropped; ovf_cnt=1 with BM_SCHED_STATS_EN defined, 0 without.
REQ-027 FIFO holds 7 samples, bm_v and a grant in the same cycle -> pair dropped (pre-pop occupancy 7), one sample popped, ovf_cnt incremented.
REQ-028 reseed pulsed mid-WARM with the FIFO non-empty -> LOAD next cycle, FIFO empty, gnt=0, the warm-up count restarts at 0, and ovf_cnt is preserved.
REQ-029 reset driven low during RUN with dout_valid=1 -> all outputs reach the REQ-015 values immediately, without waiting for a clk edge.
